cube_line_raster: RTL and testbench
===================================

# cube_line_raster

Sequencer and Bresenham rasteriser that sits directly downstream of the cube line generator. On `start` it walks `line_id` from 0 to NUM_LINES-1, samples each line's endpoints and color, and emits every pixel of that line, endpoints inclusive, as a valid/ready pixel stream. The stream feeds the framebuffer write port of the VGA cube display.

## Interface
Parameters:
- XY_BITW, 16: coordinate width.
- LINEW, 4: line_id width.
- COLORW, 3: color width.
- NUM_LINES, 12: number of lines per frame; 1..2^LINEW.
- X_OFF, 0: screen X offset added to every emitted pixel.
- Y_OFF, 0: screen Y offset added to every emitted pixel.

Ports:
- clk  in  1  clock. One clock domain; synchronous, active-high reset on `rst`.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin one frame; sampled only in IDLE.
- busy  out  1  high in FETCH, SETUP, DRAW and NEXT.
- done  out  1  one-cycle pulse when the frame is complete.
- line_id  out  LINEW  index of the line requested from the generator.
- color_in  in  COLORW  line color, combinational from the generator.
- x0_in, y0_in, x1_in, y1_in  in  XY_BITW each  line endpoints, unsigned.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts the pixel.
- pix_x, pix_y  out  XY_BITW each  pixel coordinate with offset applied.
- pix_color  out  COLORW  pixel color.

## Operation
- State machine states: IDLE, FETCH, SETUP, DRAW, NEXT, DONE.
- IDLE: if `start`=1, set line_id to 0 and go to FETCH. Otherwise stay.
- FETCH: line_id is stable. At the end of the cycle, register x0/y0/x1/y1/color. Go to SETUP.
- SETUP:
  - dx = |x1-x0|, sx = (x0<x1) ? +1 : -1.
  - dy = -|y1-y0|, sy = (y0<y1) ? +1 : -1.
  - err = dx+dy; current point (cx,cy) = (x0,y0).
  - Go to DRAW.
- DRAW: pix_valid=1, pix_x=cx+X_OFF, pix_y=cy+Y_OFF, pix_color=latched color.
  - On handshake (pix_valid & pix_ready):
    - If (cx,cy)==(x1,y1), go to NEXT.
    - Otherwise compute e2=2*err. If e2>=dy: err+=dy, cx+=sx. If e2<=dx: err+=dx, cy+=sy. Both updates use the pre-step err, and both may apply in the same cycle.
- NEXT: if line_id==NUM_LINES-1, go to DONE. Otherwise line_id+=1 and go to FETCH.
- DONE: done=1 for one cycle, then go to IDLE. line_id holds its last value until the next start.
- Arithmetic widths:
  - dx, dy: signed XY_BITW+1 bits.
  - err, e2: signed XY_BITW+2 bits.
  - cx, cy: XY_BITW bits.
  - Offset addition wraps modulo 2^XY_BITW.
- Zero-length line (x0=x1, y0=y1): exactly one pixel.
- Horizontal, vertical and reversed-direction lines are handled by sx/sy. The pixel order always runs from (x0,y0) to (x1,y1).
- start while busy or in DONE: ignored. No queueing.

## Timing
- Reset values: busy=0, done=0, pix_valid=0, line_id=0, pix_x=0, pix_y=0, pix_color=0. State returns to IDLE.
- Reset mid-operation: a frame in flight is abandoned at the clock edge where rst=1. pix_valid drops even without a handshake; reset is the only exception to the hold rule.
- Start latency: start sampled at edge N → FETCH in cycle N+1 → SETUP in N+2 → first pix_valid in cycle N+3.
- Throughput: one pixel per cycle while pix_ready=1.
- Gap between lines: 3 cycles with pix_valid=0 (NEXT, FETCH, SETUP).
- Handshake hold rule: while pix_valid=1 and pix_ready=0, pix_x, pix_y and pix_color are held stable. pix_valid never drops without a handshake.
- pix_valid does not depend combinationally on pix_ready.
- done pulse: asserted in the cycle after the handshake of the last pixel plus the NEXT cycle, i.e. 2 cycles after that handshake. busy=0 during DONE.
- Endpoint inputs are only required to be stable during FETCH.

## Test plan
- Default cube from the generator (W=H=10, D=5), pix_ready tied to 1 → exactly 112 pixels: 8 edges of 11 pixels plus 4 diagonals of 6 pixels, e.g. line 8 emits (0,0)…(5,5). done pulses once, 2 cycles after the 112th handshake; first pix_valid 3 cycles after start.
- NUM_LINES=1, stub line (0,0)→(2,5), color 3'b101 → pixel sequence (0,0),(0,1),(1,2),(1,3),(2,4),(2,5), all with pix_color=5.
- Reversed horizontal line (10,0)→(0,0) plus zero-length line (7,7)→(7,7), X_OFF=100, Y_OFF=20 → pix_x runs 110 down to 100 with pix_y=20, then a single pixel (107,27).
- Random pix_ready (about 50% duty) on the full cube → identical pixel sequence to the ready-always run. pix_x/pix_y/pix_color are never changed and pix_valid never dropped while pix_ready=0.
- start pulsed again during DRAW → ignored, exactly one done pulse. start pulsed in IDLE after done → a second complete frame.
- rst asserted for 1 cycle mid-line 5 → next cycle all outputs at reset values and state IDLE. A subsequent start produces a full 112-pixel frame beginning at line 0.

Source files
------------

// File: rtl/cube_line_raster.sv
// cube_line_raster: walks every cube line and rasterises it with Bresenham into a valid/ready pixel stream
module cube_line_raster #(
  parameter int XY_BITW = 16,
  parameter int LINEW = 4,
  parameter int COLORW = 3,
  parameter int NUM_LINES = 12,
  parameter int X_OFF = 0,
  parameter int Y_OFF = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [LINEW-1:0]   line_id,
  input  logic [COLORW-1:0]  color_in,
  input  logic [XY_BITW-1:0] x0_in,
  input  logic [XY_BITW-1:0] y0_in,
  input  logic [XY_BITW-1:0] x1_in,
  input  logic [XY_BITW-1:0] y1_in,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [XY_BITW-1:0] pix_x,
  output logic [XY_BITW-1:0] pix_y,
  output logic [COLORW-1:0]  pix_color
);
  localparam int EW = XY_BITW + 2;
  localparam logic [XY_BITW-1:0] XO = XY_BITW'(X_OFF);
  localparam logic [XY_BITW-1:0] YO = XY_BITW'(Y_OFF);
  localparam logic [XY_BITW-1:0] ONE = XY_BITW'(1);
  localparam logic [LINEW-1:0] LAST = LINEW'(NUM_LINES - 1);
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, DRAW, NEXT, DONE} state_t;
  state_t state;
  logic [XY_BITW-1:0] x0, y0, x1, y1, cx, cy, nx, ny, adx, ady;
  logic [COLORW-1:0] color;
  logic signed [XY_BITW:0] dx, dy;
  logic signed [EW-1:0] err, e2, err_n, dx_e, dy_e;
  logic sx, sy, step_x, step_y, at_end;
  always_comb begin
    adx = x1 > x0 ? x1 - x0 : x0 - x1;
    ady = y1 > y0 ? y1 - y0 : y0 - y1;
    dx_e = EW'(dx);
    dy_e = EW'(dy);
    e2 = err <<< 1;
    step_x = e2 >= dy_e;
    step_y = e2 <= dx_e;
    err_n = err + (step_x ? dy_e : EW'(0)) + (step_y ? dx_e : EW'(0));
    nx = step_x ? (sx ? cx + ONE : cx - ONE) : cx;
    ny = step_y ? (sy ? cy + ONE : cy - ONE) : cy;
    at_end = cx == x1 && cy == y1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pix_valid <= 1'b0;
      line_id <= '0;
      pix_x <= '0;
      pix_y <= '0;
      pix_color <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          line_id <= '0;
          busy <= 1'b1;
          state <= FETCH;
        end
        FETCH: begin
          x0 <= x0_in;
          y0 <= y0_in;
          x1 <= x1_in;
          y1 <= y1_in;
          color <= color_in;
          state <= SETUP;
        end
        SETUP: begin
          dx <= $signed({1'b0, adx});
          dy <= -$signed({1'b0, ady});
          err <= EW'(adx) - EW'(ady);
          sx <= x0 < x1;
          sy <= y0 < y1;
          cx <= x0;
          cy <= y0;
          pix_x <= x0 + XO;
          pix_y <= y0 + YO;
          pix_color <= color;
          pix_valid <= 1'b1;
          state <= DRAW;
        end
        DRAW: if (pix_ready) begin
          if (at_end) begin
            pix_valid <= 1'b0;
            state <= NEXT;
          end else begin
            err <= err_n;
            cx <= nx;
            cy <= ny;
            pix_x <= nx + XO;
            pix_y <= ny + YO;
          end
        end
        NEXT: if (line_id == LAST) begin
          busy <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end else begin
          line_id <= line_id + LINEW'(1);
          state <= FETCH;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cube_line_raster.sv
// tb_cube_line_raster: directed checks of the cube frame, an offset/reversed/zero-length pair and a steep stub line
module tb_cube_line_raster;
  typedef struct {int x0, y0, x1, y1, color, npix;} line_t;
  typedef struct {int x, y;} pt_t;
  line_t cube [12];
  pt_t stub [6];
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  logic rst = 1'b1, start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, pix_ready_a = 1'b1;
  bit rnd_mode = 1'b0;
  logic busy_a, done_a, pix_valid_a, busy_b, done_b, pix_valid_b, busy_c, done_c, pix_valid_c;
  logic [3:0] line_id_a, line_id_b, line_id_c;
  logic [2:0] color_a, color_b, pix_color_a, pix_color_b, pix_color_c;
  logic [15:0] x0_a, y0_a, x1_a, y1_a, x0_b, y0_b, x1_b, y1_b;
  logic [15:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b, pix_x_c, pix_y_c;
  logic [34:0] pix_a, pix_b, pix_c;
  assign pix_a = {pix_x_a, pix_y_a, pix_color_a};
  assign pix_b = {pix_x_b, pix_y_b, pix_color_b};
  assign pix_c = {pix_x_c, pix_y_c, pix_color_c};
  always_comb begin
    x0_a = 16'(cube[int'(line_id_a)].x0);
    y0_a = 16'(cube[int'(line_id_a)].y0);
    x1_a = 16'(cube[int'(line_id_a)].x1);
    y1_a = 16'(cube[int'(line_id_a)].y1);
    color_a = 3'(cube[int'(line_id_a)].color);
  end
  assign x0_b = line_id_b == 4'd0 ? 16'd10 : 16'd7;
  assign y0_b = line_id_b == 4'd0 ? 16'd0 : 16'd7;
  assign x1_b = line_id_b == 4'd0 ? 16'd0 : 16'd7;
  assign y1_b = line_id_b == 4'd0 ? 16'd0 : 16'd7;
  assign color_b = line_id_b == 4'd0 ? 3'd6 : 3'd2;

  cube_line_raster dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .line_id(line_id_a),
    .color_in(color_a), .x0_in(x0_a), .y0_in(y0_a), .x1_in(x1_a), .y1_in(y1_a),
    .pix_valid(pix_valid_a), .pix_ready(pix_ready_a), .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_color(pix_color_a));
  cube_line_raster #(.NUM_LINES(2), .X_OFF(100), .Y_OFF(20)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .line_id(line_id_b),
    .color_in(color_b), .x0_in(x0_b), .y0_in(y0_b), .x1_in(x1_b), .y1_in(y1_b),
    .pix_valid(pix_valid_b), .pix_ready(1'b1), .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_color(pix_color_b));
  cube_line_raster #(.NUM_LINES(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c), .line_id(line_id_c),
    .color_in(3'd5), .x0_in(16'd0), .y0_in(16'd0), .x1_in(16'd2), .y1_in(16'd5),
    .pix_valid(pix_valid_c), .pix_ready(1'b1), .pix_x(pix_x_c), .pix_y(pix_y_c), .pix_color(pix_color_c));

  task automatic chk(input string name, input longint got, input longint want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask
  function automatic longint pack(input int x, input int y, input int c);
    return (longint'(x & 16'hffff) << 19) | (longint'(y & 16'hffff) << 3) | longint'(c & 7);
  endfunction
  function automatic int sgn(input int d);
    return d > 0 ? 1 : (d < 0 ? -1 : 0);
  endfunction

  always @(posedge clk) begin
    #1 pix_ready_a = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  longint got_a[$], got_b[$], got_c[$], want_a[$];
  int done_cnt_a = 0, done_cyc_a = 0, hs_cyc_a = 0, done_cnt_b = 0, done_cnt_c = 0;
  bit stall_prev = 1'b0;
  longint prev_pix = 0;
  always @(negedge clk) begin
    if (stall_prev) begin
      chk("hold_valid", longint'(pix_valid_a), 1);
      chk("hold_pix", longint'(pix_a), prev_pix);
    end
    stall_prev = pix_valid_a && !pix_ready_a && !rst;
    prev_pix = longint'(pix_a);
    if (pix_valid_a && pix_ready_a) begin
      got_a.push_back(longint'(pix_a));
      hs_cyc_a = cyc;
    end
    if (done_a) begin
      done_cnt_a++;
      done_cyc_a = cyc;
    end
    if (pix_valid_b) got_b.push_back(longint'(pix_b));
    if (pix_valid_c) got_c.push_back(longint'(pix_c));
    if (done_b) done_cnt_b++;
    if (done_c) done_cnt_c++;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, longint'(busy_a), 0);
    chk({tag, "_done"}, longint'(done_a), 0);
    chk({tag, "_valid"}, longint'(pix_valid_a), 0);
    chk({tag, "_line_id"}, longint'(line_id_a), 0);
    chk({tag, "_pix_x"}, longint'(pix_x_a), 0);
    chk({tag, "_pix_y"}, longint'(pix_y_a), 0);
    chk({tag, "_pix_color"}, longint'(pix_color_a), 0);
  endtask

  task automatic run_frame_a(input string tag, input bit poke, input bit timed);
    int c0, lat, n;
    got_a.delete();
    done_cnt_a = 0;
    c0 = cyc;
    start_a = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start_a = 1'b0;
      lat++;
    end while (!pix_valid_a && lat < 20);
    chk({tag, "_first_valid_latency"}, lat, 3);
    if (poke) begin
      repeat (20) @(negedge clk);
      chk({tag, "_busy_at_poke"}, longint'(busy_a), 1);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    n = 0;
    while (done_cnt_a == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk({tag, "_done_pulses"}, done_cnt_a, 1);
    chk({tag, "_idle_busy"}, longint'(busy_a), 0);
    chk({tag, "_line_id_hold"}, longint'(line_id_a), 11);
    chk({tag, "_done_after_last_hs"}, done_cyc_a - hs_cyc_a, 2);
    if (timed) chk({tag, "_frame_cycles"}, done_cyc_a - c0, 149);
    chk({tag, "_pixel_count"}, got_a.size(), want_a.size());
    for (int i = 0; i < want_a.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i), got_a.size() > i ? got_a[i] : -1, want_a[i]);
  endtask

  initial begin
    int n;
    cube = '{'{0, 0, 10, 0, 1, 11}, '{10, 0, 10, 10, 2, 11}, '{10, 10, 0, 10, 3, 11}, '{0, 10, 0, 0, 4, 11},
             '{5, 5, 15, 5, 5, 11}, '{15, 5, 15, 15, 6, 11}, '{15, 15, 5, 15, 7, 11}, '{5, 15, 5, 5, 1, 11},
             '{0, 0, 5, 5, 2, 6}, '{10, 0, 15, 5, 3, 6}, '{10, 10, 15, 15, 4, 6}, '{0, 10, 5, 15, 5, 6}};
    stub = '{'{0, 0}, '{0, 1}, '{1, 2}, '{1, 3}, '{2, 4}, '{2, 5}};
    foreach (cube[l])
      for (int k = 0; k < cube[l].npix; k++)
        want_a.push_back(pack(cube[l].x0 + k * sgn(cube[l].x1 - cube[l].x0),
                              cube[l].y0 + k * sgn(cube[l].y1 - cube[l].y0), cube[l].color));
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    @(negedge clk);
    got_b.delete();
    got_c.delete();
    start_b = 1'b1;
    start_c = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    start_c = 1'b0;
    n = 0;
    while ((done_cnt_b == 0 || done_cnt_c == 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    chk("b_done_pulses", done_cnt_b, 1);
    chk("b_pixel_count", got_b.size(), 12);
    for (int i = 0; i < 11; i++)
      chk($sformatf("b_rev_pix%0d", i), got_b.size() > i ? got_b[i] : -1, pack(110 - i, 20, 6));
    chk("b_zero_len_pix", got_b.size() > 11 ? got_b[11] : -1, pack(107, 27, 2));
    chk("c_done_pulses", done_cnt_c, 1);
    chk("c_pixel_count", got_c.size(), 6);
    foreach (stub[i])
      chk($sformatf("c_stub_pix%0d", i), got_c.size() > i ? got_c[i] : -1, pack(stub[i].x, stub[i].y, 5));
    run_frame_a("cube_ready", 1'b0, 1'b1);
    rnd_mode = 1'b1;
    run_frame_a("cube_random", 1'b0, 1'b0);
    rnd_mode = 1'b0;
    repeat (3) @(negedge clk);
    run_frame_a("cube_poke", 1'b1, 1'b1);
    run_frame_a("cube_again", 1'b0, 1'b1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!(line_id_a == 4'd5 && pix_valid_a) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reached_line5", longint'(line_id_a == 4'd5 && pix_valid_a), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("midrst");
    repeat (5) @(negedge clk);
    chk("midrst_stays_idle", longint'({busy_a, pix_valid_a, done_a}), 0);
    run_frame_a("cube_after_rst", 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
